// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states,
// opcode/funct constants, ALU control codes and datapath mux selects.
package mips_ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALUC_W  = 3;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  // R-type funct field (IR[5:0])
  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  // ALU control codes
  localparam logic [ALUC_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUC_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALUC_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALUC_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALUC_W-1:0] ALU_SLT = 3'b111;

  // aluop: what the FSM asks of the ALU decoder
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [SEL_W-1:0] SRCB_B      = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMM_SH = 2'b11;

  // Next-PC source select
  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/decodificador_ula.sv
// ALU decoder: maps the FSM's aluop request plus the R-type funct field to
// the 3-bit ALU control code. Purely combinational.
//   aluop       in  2 : 00 add, 01 sub, 10 decode funct
//   funct       in  6 : IR[5:0]
//   alu_control out 3 : ALU operation code
module decodificador_ula
  import mips_ctrl_pkg::*;
(
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [FUNCT_W-1:0] funct,
  output logic [ALUC_W-1:0]  alu_control
);

  // Unknown funct falls back to add so the instruction still writes back.
  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch, decode, execute,
// memory and write-back for R-type, lw, sw, beq, addi and j.
//   ck, reset          : clock, synchronous active-high reset
//   opcode, funct, zero: IR fields and ALU zero flag
//   pc_en, ir_write, mem_write, reg_write : write enables (0 during reset)
//   iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src : mux selects
//   alu_control        : ALU operation code
//   state_dbg          : current state encoding
module controle_multiciclo
  import mips_ctrl_pkg::*;
(
  input  logic               ck,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               zero,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [SEL_W-1:0]   alu_src_b,
  output logic [ALUC_W-1:0]  alu_control,
  output logic [SEL_W-1:0]   pc_src,
  output logic [STATE_W-1:0] state_dbg
);

  state_t              state;
  state_t              state_next;

  logic                pc_write;
  logic                branch;
  logic                mem_write_st;
  logic                ir_write_st;
  logic                reg_write_st;
  logic [ALUOP_W-1:0]  aluop;

  // State register
  always_ff @(posedge ck) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Next-state logic; unused encodings recover to FETCH
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      state_next = S_MEMREAD;
        else if (opcode == OP_SW) state_next = S_MEMWRITE;
        else                      state_next = S_FETCH;
      end
      S_MEMREAD: state_next = S_MEMWB;
      S_EXECUTE: state_next = S_ALUWB;
      S_ADDIEX:  state_next = S_ADDIWB;
      default:   state_next = S_FETCH;
    endcase
  end

  // Output decode (Moore)
  always_comb begin
    pc_write     = 1'b0;
    branch       = 1'b0;
    iord         = 1'b0;
    mem_write_st = 1'b0;
    ir_write_st  = 1'b0;
    reg_write_st = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_B;
    aluop        = ALUOP_ADD;
    pc_src       = PCSRC_ALU;
    case (state)
      S_FETCH: begin
        alu_src_b   = SRCB_FOUR;
        ir_write_st = 1'b1;
        pc_write    = 1'b1;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH;
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: iord = 1'b1;
      S_MEMWRITE: begin
        iord         = 1'b1;
        mem_write_st = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg   = 1'b1;
        reg_write_st = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_dst      = 1'b1;
        reg_write_st = 1'b1;
      end
      S_ADDIWB: reg_write_st = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        branch    = 1'b1;
      end
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  decodificador_ula u_decodificador_ula (
    .aluop       (aluop),
    .funct       (funct),
    .alu_control (alu_control)
  );

  // Write enables are suppressed while reset is held so nothing commits.
  assign pc_en     = ~reset & (pc_write | (branch & zero));
  assign ir_write  = ~reset & ir_write_st;
  assign mem_write = ~reset & mem_write_st;
  assign reg_write = ~reset & reg_write_st;
  assign state_dbg = state;

endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Multicycle MIPS control unit: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and write-back cycles. It sits directly upstream of the register bank and datapath. It drives the register bank's write enable (`reg_write` → `WE3`) and the write-address/write-data muxes (`reg_dst`, `mem_to_reg`), plus the PC, IR, memory and ALU controls. Supported instructions: R-type (add, sub, and, or, slt), lw, sw, beq, addi, j.

## Interface
Parameters:
- None. All encodings are fixed in `mips_ctrl_pkg`.

Ports:
- `ck` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 6: IR[31:26]; valid from DECODE onward.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag.
- `pc_en` out 1: PC load enable, equal to `pc_write | (branch & zero)`.
- `iord` out 1: memory address select, 0=PC, 1=ALUOut.
- `mem_write` out 1: data memory write.
- `ir_write` out 1: IR load.
- `reg_write` out 1: register bank write enable (WE3).
- `reg_dst` out 1: A3 select, 0=rt, 1=rd.
- `mem_to_reg` out 1: WD3 select, 0=ALUOut, 1=Data.
- `alu_src_a` out 1: ALU A input, 0=PC, 1=A.
- `alu_src_b` out 2: ALU B input, 00=B, 01=4, 10=SignImm, 11=SignImm<<2.
- `alu_control` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `pc_src` out 2: 00=ALUResult, 01=ALUOut, 10=jump target.
- `state_dbg` out 4: current state encoding.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- Transitions:
  - FETCH→DECODE.
  - DECODE routes on `opcode`:
    - lw/sw→MEMADR.
    - R(000000)→EXECUTE.
    - beq(000100)→BRANCH.
    - addi(001000)→ADDIEX.
    - j(000010)→JUMP.
    - any other opcode→FETCH (treated as a no-op; PC already advanced).
  - MEMADR routes on `opcode`: lw(100011)→MEMREAD, sw(101011)→MEMWRITE.
  - MEMREAD→MEMWB; EXECUTE→ALUWB; ADDIEX→ADDIWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB and JUMP all return to FETCH.
  - Encodings 12–15 are illegal and go to FETCH.
- Outputs are a pure function of state (plus `funct` in EXECUTE and `zero` for `pc_en`). Defaults are 0 / ALU add.
  - FETCH: iord=0, alu_src_a=0, alu_src_b=01, add, pc_src=00, ir_write=1, pc_write=1.
  - DECODE: alu_src_a=0, alu_src_b=11, add.
  - MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10, add.
  - MEMREAD: iord=1.
  - MEMWRITE: iord=1, mem_write=1.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_control from funct.
  - ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1.
  - BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, branch=1.
  - JUMP: pc_src=10, pc_write=1.
- Funct decode (EXECUTE only): 100000→010, 100010→110, 100100→000, 100101→001, 101010→111. Any other funct→010, and the instruction still writes back.

## Timing
- Instruction latencies in cycles, FETCH inclusive: lw 5, sw 4, R 4, addi 4, beq 3, j 3, unknown opcode 2.
- `reg_write` is high for exactly one cycle per writing instruction. The register bank captures the write on the rising edge that ends that cycle.
- `pc_en` in BRANCH follows `zero` combinationally in the same cycle.
- Reset:
  - While `reset`=1, `pc_en`, `ir_write`, `reg_write` and `mem_write` are forced to 0.
  - The next edge loads FETCH regardless of the current state, including mid-instruction. There is no partial write-back.
  - After reset releases, the first cycle is FETCH with `pc_en`=1 and `ir_write`=1, `state_dbg`=0.
- `opcode` and `funct` are ignored in FETCH. The IR updates on the edge ending FETCH.

## Structure
- `mips_ctrl_pkg`: the state enum, opcode constants, funct constants, ALU control codes and `alu_src_b`/`pc_src` codes.
- Sub-module `decodificador_ula`: combinational; maps aluop (2 bits) plus funct to `alu_control`.
- Top level: state register, next-state logic, output decode.

## Test plan
- Reset held for 3 cycles with `opcode`=000000 → `state_dbg`=0 and all write enables 0. First cycle after release: `pc_en`=1, `ir_write`=1.
- lw (100011) → state sequence 0,1,2,3,4,0. In state 4: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0.
- R-type with funct 101010 → sequence 0,1,6,7,0. `alu_control`=111 in state 6. In state 7: `reg_write`=1, `reg_dst`=1.
- beq with `zero`=1 → `pc_en`=1 and `pc_src`=01 in state 8. Repeated with `zero`=0 → `pc_en`=0. Both return to 0 after 3 cycles.
- sw, addi, j and opcode 111111 → sequences 0,1,2,5,0 / 0,1,9,10,0 / 0,1,11,0 / 0,1,0. `mem_write` is high only in state 5.
- Reset asserted in MEMREAD → next state 0, with `reg_write` never asserted.
